tone_decoder: RTL and testbench

Receive-side counterpart of the square-wave tone generator: measures the half-period of an incoming single-bit tone and decodes it to the same 4-bit pitch code the generator uses (A3..A5 scale, 50 MHz clock). Sits between an external tone input pin (or a loopback of the speaker line) and game logic that needs to know which Simon button tone is sounding. Reports a stable pitch, a valid flag and a one-cycle change strobe.

---
 rtl/tone_decoder.sv | 223 ++++++++++++++++++++++
 tb/tb_tone_decoder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/tone_decoder.sv
// tone_decoder: measures the half-period of a single-bit square-wave tone and
// decodes it to the 4-bit pitch code of the tone generator (A3..A5, 50 MHz).
// Optional build macro TONE_DECODER_GLITCH_FILTER_EN: accept a transition only
// after the synchronized level has been stable for 4 clocks (edge latency 7).
// TABLE_SHIFT scales the nominal half-period table down (0 = 50 MHz values).
module tone_decoder #(
  parameter int unsigned TOL         = 512,
  parameter int unsigned MATCH_COUNT = 3,
  parameter int unsigned TIMEOUT     = 131072,
  parameter int unsigned TABLE_SHIFT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       tone_in,
  output logic [3:0] pitch,
  output logic       valid,
  output logic       changed
);

  localparam logic [17:0] TimeoutCnt = 18'(TIMEOUT);
  localparam logic [3:0]  MatchRun   = 4'(MATCH_COUNT);
  localparam logic [19:0] TolW       = 20'(TOL);

  typedef enum logic [1:0] {StIdle, StMeasure, StLocked} state_e;

  // Nominal half-period in clocks (generator divisor + 1) for each pitch code.
  function automatic logic [16:0] nominal(input logic [3:0] k);
    case (k)
      4'd0:    nominal = 17'd113637;
      4'd1:    nominal = 17'd101216;
      4'd2:    nominal = 17'd90254;
      4'd3:    nominal = 17'd85035;
      4'd4:    nominal = 17'd75759;
      4'd5:    nominal = 17'd67569;
      4'd6:    nominal = 17'd60242;
      4'd7:    nominal = 17'd56819;
      4'd8:    nominal = 17'd50608;
      4'd9:    nominal = 17'd45127;
      4'd10:   nominal = 17'd42590;
      4'd11:   nominal = 17'd37937;
      4'd12:   nominal = 17'd33785;
      4'd13:   nominal = 17'd30085;
      4'd14:   nominal = 17'd28410;
      default: nominal = 17'd0;
    endcase
  endfunction

  logic sync1_q, sync2_q, lvl_q, edge_q, src;

  // Two-flop synchronizer for the asynchronous tone input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= tone_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef TONE_DECODER_GLITCH_FILTER_EN
  logic       filt_q;
  logic [1:0] stab_q;

  // Adopt a new level only once it has been seen for 4 consecutive clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      stab_q <= 2'd0;
    end else if (sync2_q != filt_q) begin
      if (stab_q == 2'd3) begin
        filt_q <= sync2_q;
        stab_q <= 2'd0;
      end else begin
        stab_q <= stab_q + 2'd1;
      end
    end else begin
      stab_q <= 2'd0;
    end
  end

  assign src = filt_q;
`else
  assign src = sync2_q;
`endif

  // Registered edge detect: any transition of the (filtered) level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q  <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      lvl_q  <= src;
      edge_q <= src ^ lvl_q;
    end
  end

  state_e      state_q, state_d;
  logic [17:0] cnt_q, cnt_d;
  logic [3:0]  run_q, run_d, run_hit;
  logic [3:0]  cand_q, cand_d, cand;
  logic [3:0]  pitch_q, pitch_d;
  logic        valid_q, valid_d, changed_q, changed_d, hit;
  logic [19:0] h, tab;

  assign h = 20'(cnt_q) + 20'd1;

  // Window match against the table; scanning downwards lets the lowest k win.
  always_comb begin
    hit  = 1'b0;
    cand = 4'd0;
    tab  = 20'd0;
    for (int k = 14; k >= 0; k--) begin
      tab = 20'(nominal(4'(k)) >> TABLE_SHIFT);
      if ((h + TolW >= tab) && (h <= tab + TolW)) begin
        hit  = 1'b1;
        cand = 4'(k);
      end
    end
  end

  // Run length if this edge's candidate is counted: extend a run of the same
  // candidate (saturating), otherwise start a new run.
  assign run_hit = (run_q != 4'd0 && cand == cand_q) ?
                   ((run_q >= MatchRun) ? run_q : run_q + 4'd1) : 4'd1;

  // Next-state, run tracking and output decisions.
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    cand_d    = cand_q;
    pitch_d   = pitch_q;
    valid_d   = valid_q;
    changed_d = 1'b0;
    if (!en) begin
      state_d = StIdle;
      valid_d = 1'b0;
      run_d   = 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (edge_q) state_d = StMeasure;
        end
        StMeasure: begin
          if (edge_q) begin
            if (!hit) begin
              run_d = 4'd0;
            end else begin
              run_d  = run_hit;
              cand_d = cand;
              if (run_hit == MatchRun) begin
                state_d   = StLocked;
                pitch_d   = cand;
                valid_d   = 1'b1;
                changed_d = 1'b1;
              end
            end
          end else if (cnt_q == TimeoutCnt) begin
            state_d = StIdle;
            valid_d = 1'b0;
            run_d   = 4'd0;
          end
        end
        StLocked: begin
          if (edge_q) begin
            if (!hit) begin
              state_d = StMeasure;
              valid_d = 1'b0;
              run_d   = 4'd0;
            end else begin
              run_d  = run_hit;
              cand_d = cand;
              // Keep reporting the old pitch until the new one is confirmed.
              if (run_hit == MatchRun && cand != pitch_q) begin
                pitch_d   = cand;
                changed_d = 1'b1;
              end
            end
          end else if (cnt_q == TimeoutCnt) begin
            state_d = StIdle;
            valid_d = 1'b0;
            run_d   = 4'd0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Half-period counter: cleared on edges and in idle, saturating otherwise.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == StIdle || edge_q) cnt_d = 18'd0;
    else if (cnt_q != TimeoutCnt)    cnt_d = cnt_q + 18'd1;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 18'd0;
      run_q     <= 4'd0;
      cand_q    <= 4'd0;
      pitch_q   <= 4'd0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      run_q     <= run_d;
      cand_q    <= cand_d;
      pitch_q   <= pitch_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
    end
  end

  assign pitch   = pitch_q;
  assign valid   = valid_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_tone_decoder.sv
// tb_tone_decoder: directed test of tone_decoder with the table scaled by 2^-7
// (half-periods: k0=887, k3=664, k4=591, k7=443, k13=235, k14=221).
module tb_tone_decoder;

  localparam int unsigned Tol        = 4;
  localparam int unsigned MatchCount = 3;
  localparam int unsigned Timeout    = 1024;
  localparam int unsigned Shift      = 7;
`ifdef TONE_DECODER_GLITCH_FILTER_EN
  localparam int Lat      = 8;  // tone_in transition to output update, clocks
  localparam int FilterOn = 1;
`else
  localparam int Lat      = 4;
  localparam int FilterOn = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, en, tone_in;
  logic [3:0] pitch;
  logic       valid, changed;

  int since, n_checks, n_pass, chg_cnt, bad_chg;

  tone_decoder #(
    .TOL        (Tol),
    .MATCH_COUNT(MatchCount),
    .TIMEOUT    (Timeout),
    .TABLE_SHIFT(Shift)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .tone_in(tone_in),
    .pitch  (pitch),
    .valid  (valid),
    .changed(changed)
  );

  always #5 clk = ~clk;

  // Count change strobes, and any strobe seen without valid.
  always @(negedge clk) begin
    if (rst_n) begin
      if (changed) chg_cnt++;
      if (changed && !valid) bad_chg++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance n clocks; stay 1 time unit after each rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      since++;
    end
  endtask

  // Toggle the tone so that the new edge lands hp clocks after the previous one.
  task automatic toggle_at(input int hp);
    if (hp > since) step(hp - since);
    tone_in = ~tone_in;
    since   = 0;
  endtask

  task automatic tone(input int hp, input int n);
    for (int i = 0; i < n; i++) begin
      toggle_at(hp);
      step(Lat + 1);
    end
  endtask

  // One half-period with a 2-clock glitch 100 clocks after the real edge.
  task automatic glitchy(input int hp);
    step(100 - since);
    tone_in = ~tone_in;
    step(2);
    tone_in = ~tone_in;
    toggle_at(hp);
    step(Lat + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; tone_in = 1'b0;
    since = 0; n_checks = 0; n_pass = 0; chg_cnt = 0; bad_chg = 0;
    step(3);
    check("rst_pitch", 32'(pitch), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_changed", 32'(changed), 0);
    rst_n = 1'b1;
    en    = 1'b1;
    step(5);

    // Lock on the 4th edge of a k=0 tone, with exact output latency.
    tone(887, 3);
    check("lock_early", 32'(valid), 0);
    toggle_at(887);
    step(Lat - 1);
    check("lat_valid", 32'(valid), 0);
    check("lat_changed", 32'(changed), 0);
    step(1);
    check("lock_valid", 32'(valid), 1);
    check("lock_changed", 32'(changed), 1);
    check("lock_pitch", 32'(pitch), 0);
    step(1);
    check("pulse_width", 32'(changed), 0);
    tone(887, 2);
    check("hold_valid", 32'(valid), 1);
    check("one_pulse", 32'(chg_cnt), 1);

    // Switch to k=3: old pitch held for two edges, updated on the third.
    tone(664, 2);
    check("sw_pitch_hold", 32'(pitch), 0);
    check("sw_valid_hold", 32'(valid), 1);
    tone(664, 1);
    check("sw_pitch", 32'(pitch), 3);
    check("sw_pulses", 32'(chg_cnt), 2);

    // Silence: valid drops one clock after the counter reaches TIMEOUT.
    step(Timeout + Lat - since);
    check("to_before", 32'(valid), 1);
    step(1);
    check("to_valid", 32'(valid), 0);
    check("to_pitch", 32'(pitch), 3);

    // Relock from idle at k=7, then move to k=14 and probe the window edge.
    tone(443, 3);
    check("relock_early", 32'(valid), 0);
    tone(443, 1);
    check("relock_valid", 32'(valid), 1);
    check("relock_pitch", 32'(pitch), 7);
    tone(221, 2);
    check("k14_hold", 32'(pitch), 7);
    tone(221, 1);
    check("k14_pitch", 32'(pitch), 14);
    check("k14_pulses", 32'(chg_cnt), 4);
    tone(221 + Tol, 3);
    check("tol_pitch", 32'(pitch), 14);
    check("tol_valid", 32'(valid), 1);
    check("tol_pulses", 32'(chg_cnt), 4);
    tone(221 + Tol + 1, 1);
    check("tol_over", 32'(valid), 0);

    // Glitches on a k=4 tone: filtered build keeps lock, plain build loses it.
    tone(591, 3);
    check("k4_valid", 32'(valid), 1);
    check("k4_pitch", 32'(pitch), 4);
    for (int i = 0; i < 3; i++) glitchy(591);
    check("glitch_valid", 32'(valid), 32'(FilterOn));
    check("glitch_pitch", 32'(pitch), 4);

    // Asynchronous reset while locked.
    tone(591, 3);
    check("pre_rst_valid", 32'(valid), 1);
    step(50);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(valid), 0);
    check("arst_pitch", 32'(pitch), 0);
    tone_in = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(10);

    // Enable drop while locked.
    tone(591, 4);
    check("en_lock_valid", 32'(valid), 1);
    check("en_lock_pitch", 32'(pitch), 4);
    en = 1'b0;
    step(1);
    check("en_valid", 32'(valid), 0);
    tone(591, 4);
    check("en_off_valid", 32'(valid), 0);
    check("en_off_pitch", 32'(pitch), 4);
    check("chg_without_valid", 32'(bad_chg), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
